// File: rtl/nios_system_cpu_mult_pipe.sv
// Pipelined integer multiplier for the Nios II execute path: MUL/MULXSS/MULXSU/MULXUU
// built from 16x16 unsigned partial products with sign correction, stall/flush aware.
module nios_system_cpu_mult_pipe #(
    parameter int WIDTH               = 32,
    parameter int LATENCY             = 2,
    parameter bit ROUND_ZERO_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             busy
);

    localparam int NSEG  = WIDTH / 16;
    localparam int NPP   = NSEG * NSEG;
    localparam int PW    = 2 * WIDTH;
    localparam int EXTRA = (LATENCY > 2) ? LATENCY - 2 : 0;

    function automatic logic [WIDTH-1:0] select_half(input logic [PW-1:0] p, input logic [1:0] o);
        return (o == 2'b00) ? p[WIDTH-1:0] : p[PW-1:WIDTH];
    endfunction

    // Stage 0: operand extension, partial products and sign-correction term
    logic signed [WIDTH:0] ext1_p0;
    logic signed [WIDTH:0] ext2_p0;
    logic [31:0]           pp_p0 [NPP];
    logic [WIDTH:0]        corr_p0;

    always_comb begin
        ext1_p0 = signed'({(op == 2'b01 || op == 2'b10) & src1[WIDTH-1], src1});
        ext2_p0 = signed'({(op == 2'b01) & src2[WIDTH-1], src2});
        for (int i = 0; i < NSEG; i++) begin
            for (int j = 0; j < NSEG; j++) begin
                pp_p0[i*NSEG+j] = 32'(ext1_p0[16*i +: 16]) * 32'(ext2_p0[16*j +: 16]);
            end
        end
        // A*B over WIDTH+1 bits = Au*Bu - (s1*Bu + s2*Au) << WIDTH, mod 2^(2*WIDTH)
        corr_p0 = (ext1_p0[WIDTH] ? {1'b0, ext2_p0[WIDTH-1:0]} : '0)
                + (ext2_p0[WIDTH] ? {1'b0, ext1_p0[WIDTH-1:0]} : '0);
    end

    logic [31:0]    pp_t [NPP];
    logic [WIDTH:0] corr_t;
    logic [1:0]     op_t;
    logic           vld_t;
    logic           busy_p1;

    // Stage 1: registered partial products
    generate
        if (LATENCY >= 2) begin : g_pp_reg
            logic [31:0]    pp_p1 [NPP];
            logic [WIDTH:0] corr_p1;
            logic [1:0]     op_p1;
            logic           vld_p1;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < NPP; k++) pp_p1[k] <= '0;
                    corr_p1 <= '0;
                    op_p1   <= '0;
                    vld_p1  <= 1'b0;
                end else if (flush) begin
                    vld_p1 <= 1'b0;
                end else if (!stall) begin
                    for (int k = 0; k < NPP; k++) pp_p1[k] <= pp_p0[k];
                    corr_p1 <= corr_p0;
                    op_p1   <= op;
                    vld_p1  <= in_valid;
                end
            end

            assign pp_t    = pp_p1;
            assign corr_t  = corr_p1;
            assign op_t    = op_p1;
            assign vld_t   = vld_p1;
            assign busy_p1 = vld_p1;
        end else begin : g_pp_comb
            assign pp_t    = pp_p0;
            assign corr_t  = corr_p0;
            assign op_t    = op;
            assign vld_t   = in_valid;
            assign busy_p1 = 1'b0;
        end
    endgenerate

    logic [PW-1:0] prod_t;

    always_comb begin
        prod_t = -(PW'(corr_t) << WIDTH);
        for (int i = 0; i < NSEG; i++) begin
            for (int j = 0; j < NSEG; j++) begin
                prod_t = prod_t + (PW'(pp_t[i*NSEG+j]) << (16 * (i + j)));
            end
        end
    end

    logic [PW-1:0] prod_f;
    logic [1:0]    op_f;
    logic          vld_f;
    logic          busy_p2;

    // Stage 2..: post-tree retiming registers
    generate
        if (EXTRA > 0) begin : g_tail
            logic [PW-1:0] prod_p2 [EXTRA];
            logic [1:0]    op_p2   [EXTRA];
            logic          vld_p2  [EXTRA];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < EXTRA; k++) begin
                        prod_p2[k] <= '0;
                        op_p2[k]   <= '0;
                        vld_p2[k]  <= 1'b0;
                    end
                end else if (flush) begin
                    for (int k = 0; k < EXTRA; k++) vld_p2[k] <= 1'b0;
                end else if (!stall) begin
                    prod_p2[0] <= prod_t;
                    op_p2[0]   <= op_t;
                    vld_p2[0]  <= vld_t;
                    for (int k = 1; k < EXTRA; k++) begin
                        prod_p2[k] <= prod_p2[k-1];
                        op_p2[k]   <= op_p2[k-1];
                        vld_p2[k]  <= vld_p2[k-1];
                    end
                end
            end

            always_comb begin
                busy_p2 = 1'b0;
                for (int k = 0; k < EXTRA; k++) busy_p2 = busy_p2 | vld_p2[k];
            end

            assign prod_f = prod_p2[EXTRA-1];
            assign op_f   = op_p2[EXTRA-1];
            assign vld_f  = vld_p2[EXTRA-1];
        end else begin : g_no_tail
            assign prod_f  = prod_t;
            assign op_f    = op_t;
            assign vld_f   = vld_t;
            assign busy_p2 = 1'b0;
        end
    endgenerate

    // Output stage: half select; result keeps the last valid value across bubbles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            if (ROUND_ZERO_ON_FLUSH) result <= '0;
        end else if (!stall) begin
            out_valid <= vld_f;
            if (vld_f) result <= select_half(prod_f, op_f);
        end
    end

    assign busy = busy_p1 | busy_p2 | out_valid;

endmodule

// File: tb/tb_nios_system_cpu_mult_pipe.sv
// Scoreboard bench for nios_system_cpu_mult_pipe: a 32-bit/2-stage zero-on-flush instance
// and a 64-bit/4-stage hold-on-flush instance share one stimulus stream.
module tb_nios_system_cpu_mult_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  op;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        stall;
    logic        flush;
    logic [31:0] res_a;
    logic        ov_a;
    logic        busy_a;
    logic [63:0] res_b;
    logic        ov_b;
    logic        busy_b;

    always #5 clk = ~clk;

    nios_system_cpu_mult_pipe #(.WIDTH(32), .LATENCY(2), .ROUND_ZERO_ON_FLUSH(1'b1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op),
        .src1(src1[31:0]), .src2(src2[31:0]), .stall(stall), .flush(flush),
        .result(res_a), .out_valid(ov_a), .busy(busy_a)
    );

    nios_system_cpu_mult_pipe #(.WIDTH(64), .LATENCY(4), .ROUND_ZERO_ON_FLUSH(1'b0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op),
        .src1(src1), .src2(src2), .stall(stall), .flush(flush),
        .result(res_b), .out_valid(ov_b), .busy(busy_b)
    );

    typedef struct {
        logic [63:0] val;
        int          due;
    } exp_t;

    typedef struct {
        bit          v;
        logic [1:0]  o;
        logic [63:0] a;
        logic [63:0] b;
        bit          s;
        bit          f;
        bit          ovr;
        logic [31:0] e;
    } stim_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   acnt   = 0;
    bit   upd    = 1'b0;

    // Reference: exact signed product of the (w+1)-bit extended operands.
    function automatic logic [63:0] ref_mul(input int w, input logic [1:0] o,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [63:0]         mask;
        logic signed [129:0] x, y, p, one;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        one  = 130'sd1;
        x    = $signed({66'd0, a & mask});
        y    = $signed({66'd0, b & mask});
        if ((o == 2'b01 || o == 2'b10) && a[w-1]) x = x - (one <<< w);
        if (o == 2'b01 && b[w-1]) y = y - (one <<< w);
        p = x * y;
        if (o == 2'b00) return p[63:0] & mask;
        return 64'(p >>> w) & mask;
    endfunction

    function automatic stim_t mk(input bit v, input logic [1:0] o, input logic [63:0] a,
                                 input logic [63:0] b, input bit s, input bit f,
                                 input bit ovr, input logic [31:0] e);
        stim_t st;
        st.v = v; st.o = o; st.a = a; st.b = b; st.s = s; st.f = f; st.ovr = ovr; st.e = e;
        return st;
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '1;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'h0000_0000_8000_0000;
            3: return 64'd0;
            4: return 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Drives one cycle, records expectations of accepted ops, returns #1 after the edge.
    task automatic drive(input stim_t st);
        exp_t e;
        in_valid = st.v; op = st.o; src1 = st.a; src2 = st.b; stall = st.s; flush = st.f;
        @(posedge clk);
        if (st.f) begin
            qa.delete();
            qb.delete();
        end else if (!st.s) begin
            if (st.v) begin
                e.val = st.ovr ? {32'd0, st.e} : ref_mul(32, st.o, st.a, st.b);
                e.due = acnt + 2;
                qa.push_back(e);
                e.val = ref_mul(64, st.o, st.a, st.b);
                e.due = acnt + 4;
                qb.push_back(e);
            end
            acnt++;
        end
        upd = st.f || !st.s;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; op = 2'b00; src1 = '0; src2 = '0; stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (res_a !== 32'd0) begin errors++; $display("FAIL reset_result_a got %h want 0", res_a); end
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid_a got %b want 0", ov_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a got %b want 0", busy_a); end
        checks++; if (res_b !== 64'd0) begin errors++; $display("FAIL reset_result_b got %h want 0", res_b); end
        checks++; if (ov_b !== 1'b0) begin errors++; $display("FAIL reset_out_valid_b got %b want 0", ov_b); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b got %b want 0", busy_b); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_all_ones();
        stim_t tbl[$];
        bit ev;
        tbl.push_back(mk(1'b1, 2'b00, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0000_0001));
        tbl.push_back(mk(1'b1, 2'b11, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE));
        tbl.push_back(mk(1'b1, 2'b01, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0000_0000));
        tbl.push_back(mk(1'b1, 2'b10, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF));
        repeat (3) tbl.push_back(mk(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            ev = 1'b0;
            if (qa.size() > 0) ev = (qa[0].due == acnt);
            checks++;
            if (ov_a !== ev) begin errors++; $display("FAIL all_ones out_valid step %0d got %b want %b", i, ov_a, ev); end
            if (ev) begin
                checks++;
                if (res_a !== qa[0].val[31:0]) begin errors++; $display("FAIL all_ones result step %0d got %h want %h", i, res_a, qa[0].val[31:0]); end
                void'(qa.pop_front());
            end
        end
    endtask

    task automatic test_corners();
        stim_t tbl[$];
        bit ev;
        tbl.push_back(mk(1'b1, 2'b01, 64'h8000_0000, 64'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h4000_0000));
        tbl.push_back(mk(1'b1, 2'b00, 64'h0001_0000, 64'h0001_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000));
        tbl.push_back(mk(1'b1, 2'b11, 64'h0001_0000, 64'h0001_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0001));
        tbl.push_back(mk(1'b1, 2'b10, 64'h8000_0000, 64'h8000_0000, 1'b0, 1'b0, 1'b1, 32'hC000_0000));
        repeat (3) tbl.push_back(mk(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            ev = 1'b0;
            if (qa.size() > 0) ev = (qa[0].due == acnt);
            checks++;
            if (ov_a !== ev) begin errors++; $display("FAIL corners out_valid step %0d got %b want %b", i, ov_a, ev); end
            if (ev) begin
                checks++;
                if (res_a !== qa[0].val[31:0]) begin errors++; $display("FAIL corners result step %0d got %h want %h", i, res_a, qa[0].val[31:0]); end
                void'(qa.pop_front());
            end
        end
    endtask

    task automatic test_stall();
        stim_t tbl[$];
        bit ev;
        logic pov;
        logic [31:0] pres;
        tbl.push_back(mk(1'b1, 2'b11, 64'd7, 64'd9, 1'b0, 1'b0, 1'b0, 32'd0));
        tbl.push_back(mk(1'b1, 2'b01, 64'hFFFF_FFFD, 64'd5, 1'b0, 1'b0, 1'b0, 32'd0));
        tbl.push_back(mk(1'b1, 2'b10, 64'h8000_0000, 64'd3, 1'b1, 1'b0, 1'b0, 32'd0));
        tbl.push_back(mk(1'b1, 2'b10, 64'h8000_0000, 64'd3, 1'b1, 1'b0, 1'b0, 32'd0));
        tbl.push_back(mk(1'b1, 2'b10, 64'h8000_0000, 64'd3, 1'b0, 1'b0, 1'b0, 32'd0));
        repeat (4) tbl.push_back(mk(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0));
        foreach (tbl[i]) begin
            pov = ov_a;
            pres = res_a;
            drive(tbl[i]);
            if (upd) begin
                ev = 1'b0;
                if (qa.size() > 0) ev = (qa[0].due == acnt);
                checks++;
                if (ov_a !== ev) begin errors++; $display("FAIL stall out_valid step %0d got %b want %b", i, ov_a, ev); end
                if (ev) begin
                    checks++;
                    if (res_a !== qa[0].val[31:0]) begin errors++; $display("FAIL stall result step %0d got %h want %h", i, res_a, qa[0].val[31:0]); end
                    void'(qa.pop_front());
                end
            end else begin
                checks++;
                if (ov_a !== pov || res_a !== pres) begin
                    errors++; $display("FAIL stall_hold step %0d got %b/%h want %b/%h", i, ov_a, res_a, pov, pres);
                end
                checks++;
                if (busy_a !== 1'b1) begin errors++; $display("FAIL stall_busy step %0d got %b want 1", i, busy_a); end
            end
        end
    endtask

    task automatic test_flush();
        stim_t tbl[$];
        bit ev;
        tbl.push_back(mk(1'b1, 2'b11, '1, '1, 1'b0, 1'b0, 1'b0, 32'd0));
        repeat (6) tbl.push_back(mk(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            ev = 1'b0;
            if (qa.size() > 0) ev = (qa[0].due == acnt);
            checks++;
            if (ov_a !== ev) begin errors++; $display("FAIL flush_setup out_valid step %0d got %b want %b", i, ov_a, ev); end
            if (ev) begin
                checks++;
                if (res_a !== qa[0].val[31:0]) begin errors++; $display("FAIL flush_setup result got %h want %h", res_a, qa[0].val[31:0]); end
                void'(qa.pop_front());
            end
        end
        drive(mk(1'b1, 2'b00, 64'd3, 64'd5, 1'b0, 1'b0, 1'b0, 32'd0));
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL flush_busy_inflight got %b want 1", busy_a); end
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL flush_early_valid got %b want 0", ov_a); end
        drive(mk(1'b1, 2'b01, 64'd7, 64'd7, 1'b1, 1'b1, 1'b0, 32'd0));
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL flush_out_valid_a got %b want 0", ov_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL flush_busy_a got %b want 0", busy_a); end
        checks++; if (res_a !== 32'd0) begin errors++; $display("FAIL flush_zero_result_a got %h want 0", res_a); end
        checks++; if (ov_b !== 1'b0) begin errors++; $display("FAIL flush_out_valid_b got %b want 0", ov_b); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL flush_busy_b got %b want 0", busy_b); end
        checks++;
        if (res_b !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++; $display("FAIL flush_hold_result_b got %h want fffffffffffffffe", res_b);
        end
        for (int i = 0; i < 5; i++) begin
            drive(mk(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0));
            checks++;
            if (ov_a !== 1'b0 || ov_b !== 1'b0) begin
                errors++; $display("FAIL flush_no_output step %0d got %b/%b want 0/0", i, ov_a, ov_b);
            end
        end
    endtask

    task automatic test_reset_midflight();
        stim_t tbl[$];
        bit ev;
        drive(mk(1'b1, 2'b01, 64'hFFFF_FFFD, 64'd5, 1'b0, 1'b0, 1'b0, 32'd0));
        drive(mk(1'b1, 2'b11, 64'hFFFF_FFFF, 64'd2, 1'b0, 1'b0, 1'b0, 32'd0));
        checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL midreset_pre_valid got %b want 1", ov_a); end
        reset = 1'b1;
        #1;
        checks++; if (res_a !== 32'd0) begin errors++; $display("FAIL midreset_result_a got %h want 0", res_a); end
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL midreset_out_valid_a got %b want 0", ov_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midreset_busy_a got %b want 0", busy_a); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL midreset_busy_b got %b want 0", busy_b); end
        @(negedge clk);
        reset = 1'b0;
        qa.delete();
        qb.delete();
        tbl.push_back(mk(1'b1, 2'b11, 64'h1234_5678, 64'h9ABC_DEF0, 1'b0, 1'b0, 1'b0, 32'd0));
        repeat (4) tbl.push_back(mk(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            ev = 1'b0;
            if (qa.size() > 0) ev = (qa[0].due == acnt);
            checks++;
            if (ov_a !== ev) begin errors++; $display("FAIL midreset_after out_valid step %0d got %b want %b", i, ov_a, ev); end
            if (ev) begin
                checks++;
                if (res_a !== qa[0].val[31:0]) begin errors++; $display("FAIL midreset_after result got %h want %h", res_a, qa[0].val[31:0]); end
                void'(qa.pop_front());
            end
        end
    endtask

    task automatic test_random();
        stim_t st;
        bit ev;
        logic pov_a, pov_b;
        logic [31:0] pres_a;
        logic [63:0] pres_b;
        repeat (6) drive(mk(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0));
        qa.delete();
        qb.delete();
        for (int i = 0; i < 1500; i++) begin
            st = mk(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0), 1'b0, 32'd0);
            pov_a = ov_a; pres_a = res_a; pov_b = ov_b; pres_b = res_b;
            drive(st);
            if (upd) begin
                ev = 1'b0;
                if (qa.size() > 0) ev = (qa[0].due == acnt);
                checks++;
                if (ov_a !== ev) begin errors++; $display("FAIL random out_valid_a cycle %0d got %b want %b", i, ov_a, ev); end
                if (ev) begin
                    checks++;
                    if (res_a !== qa[0].val[31:0]) begin errors++; $display("FAIL random result_a cycle %0d got %h want %h", i, res_a, qa[0].val[31:0]); end
                    void'(qa.pop_front());
                end
                ev = 1'b0;
                if (qb.size() > 0) ev = (qb[0].due == acnt);
                checks++;
                if (ov_b !== ev) begin errors++; $display("FAIL random out_valid_b cycle %0d got %b want %b", i, ov_b, ev); end
                if (ev) begin
                    checks++;
                    if (res_b !== qb[0].val) begin errors++; $display("FAIL random result_b cycle %0d got %h want %h", i, res_b, qb[0].val); end
                    void'(qb.pop_front());
                end
            end else begin
                checks++;
                if (ov_a !== pov_a || res_a !== pres_a || ov_b !== pov_b || res_b !== pres_b) begin
                    errors++; $display("FAIL random stall_hold cycle %0d got %b/%h %b/%h want %b/%h %b/%h",
                                       i, ov_a, res_a, ov_b, res_b, pov_a, pres_a, pov_b, pres_b);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all_ones();
        test_corners();
        test_stall();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
